merge_output_drain: RTL

- Downstream stage of the two-list merge core.
- Pops the merge result FIFO, which has standard non-FWFT timing: dout is valid one cycle after rd_en.
- Presents the popped words as a valid/ready stream with a last marker, counts the words, and checks ascending order.
- Signals completion with a level done/start handshake, the same handshake the merge core uses.

---
 rtl/merge_output_drain.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/merge_output_drain.sv
// Output stage of the two-list merge core: pops the merge FIFO (non-FWFT),
// buffers words in a 2-entry skid FIFO and presents them as a valid/ready
// stream with a last marker. It also counts accepted words and flags any
// descending pair of captured words.
module merge_output_drain #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  total_len,
  input  logic              fifo_empty_merge,
  input  logic [DATA_W-1:0] fifo_rd_data_merge,
  output logic              fifo_rd_en_merge,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_count,
  output logic              order_error,
  output logic              drain_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  captured_q, captured_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              inflight_q, inflight_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              have_prev_q, have_prev_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic              pop;
  logic              issue;
  logic              last_word;
  logic [1:0]        occ_after_pop;
  logic [1:0]        slots_used;

  // Handshake and read-issue decisions; occupancy is judged after this cycle's pop
  always_comb begin
    pop           = (occ_q != 2'd0) && m_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    slots_used    = occ_after_pop + {1'b0, inflight_q};
    issue         = (state_q == S_DRAIN) && !fifo_empty_merge &&
                    (issued_q < len_q) && (slots_used <= 2'd1);
    last_word     = (wcnt_q == len_q - CNT_W'(1));
  end

  assign fifo_rd_en_merge = issue;
  assign m_valid          = (occ_q != 2'd0);
  assign m_data           = rd_ptr_q ? buf1_q : buf0_q;
  assign m_last           = m_valid && last_word;
  assign word_count       = wcnt_q;
  assign order_error      = err_q;
  assign drain_done       = (state_q == S_DONE);

  // Next-state logic: skid buffer bookkeeping, order check and FSM transitions
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    captured_d  = captured_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    inflight_d  = issue;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q - {1'b0, pop} + {1'b0, inflight_q};
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    if (issue) begin
      issued_d = issued_q + CNT_W'(1);
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      wcnt_d   = wcnt_q + CNT_W'(1);
    end

    // The FIFO dout is valid the cycle after rd_en; capture it into the tail
    if (inflight_q) begin
      if (wr_ptr_q) begin
        buf1_d = fifo_rd_data_merge;
      end else begin
        buf0_d = fifo_rd_data_merge;
      end
      wr_ptr_d    = ~wr_ptr_q;
      captured_d  = captured_q + CNT_W'(1);
      if (have_prev_q && (fifo_rd_data_merge < prev_q)) begin
        err_d = 1'b1;
      end
      prev_d      = fifo_rd_data_merge;
      have_prev_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = total_len;
          issued_d    = '0;
          captured_d  = '0;
          wcnt_d      = '0;
          err_d       = 1'b0;
          have_prev_d = 1'b0;
          rd_ptr_d    = 1'b0;
          wr_ptr_d    = 1'b0;
          occ_d       = 2'd0;
          state_d     = (total_len == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && last_word) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      captured_q  <= '0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      captured_q  <= captured_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      have_prev_q <= have_prev_d;
    end
  end

  // Data registers carry no reset; occupancy and have_prev qualify them
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

endmodule
